// File: rtl/start_text_render_pkg.sv
// Shared widths, colours and font contents for the start-screen text stages.
// Imported by the font ROM and the text render pipeline.
package start_text_render_pkg;

  localparam int RGB_W       = 12;
  localparam int FONT_ADDR_W = 11;
  localparam int FONT_DEPTH  = 2048;

  localparam logic [RGB_W-1:0] TEXT_RGB_DEF = 12'hFFF;
  localparam logic [RGB_W-1:0] RGB_BLACK    = 12'h000;

  // Generated glyph pattern used as the font table contents.
  function automatic logic [7:0] font_pattern(input logic [FONT_ADDR_W-1:0] a);
    return a[7:0] ^ {a[10:8], 5'b10110};
  endfunction

endpackage

// File: rtl/start_text_render_font_rom.sv
// 2048 x 8 font ROM, synchronous read (addr at edge N -> data after edge N).
// No reset; shared with the other text stages.
module font_rom
  import start_text_render_pkg::*;
(
  input  logic                   clk,
  input  logic [FONT_ADDR_W-1:0] addr,
  output logic [7:0]             data
);

  always_ff @(posedge clk) begin
    data <= font_pattern(addr);
  end

endmodule

// File: rtl/start_text_render.sv
// Start-screen text overlay: font lookup, blink and final RGB/sync registers.
// Two register stages, no handshake; one pixel per clk.
module start_text_render
  import start_text_render_pkg::*;
#(
  parameter int               BLINK_FRAMES = 30,
  parameter logic [RGB_W-1:0] TEXT_RGB     = TEXT_RGB_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   video_on,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   frame_tick,
  input  logic                   start_on,
  input  logic [2:0]             bit_addr,
  input  logic [FONT_ADDR_W-1:0] rom_addr,
  input  logic                   blink_en,
  input  logic [RGB_W-1:0]       bg_rgb,
  output logic                   hsync,
  output logic                   vsync,
  output logic [RGB_W-1:0]       rgb,
  output logic                   text_px
);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0]       font_word;
  logic             start_on_d;
  logic [2:0]       bit_addr_d;
  logic             video_on_d;
  logic             hsync_d;
  logic             vsync_d;
  logic [RGB_W-1:0] bg_rgb_d;
  logic [7:0]       blink_cnt;
  logic             visible;
  logic [2:0]       bit_sel;
  logic             lit;

  font_rom u_font_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (font_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_on_d <= 1'b0;
      bit_addr_d <= 3'd0;
      video_on_d <= 1'b0;
      hsync_d    <= 1'b1;
      vsync_d    <= 1'b1;
      bg_rgb_d   <= RGB_BLACK;
    end else begin
      start_on_d <= start_on;
      bit_addr_d <= bit_addr;
      video_on_d <= video_on;
      hsync_d    <= hsync_in;
      vsync_d    <= vsync_in;
      bg_rgb_d   <= bg_rgb;
    end
  end

  // Disable wins over a coincident frame_tick so blinking always restarts shown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= 8'd0;
      visible   <= 1'b1;
    end else if (!blink_en) begin
      blink_cnt <= 8'd0;
      visible   <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= 8'd0;
        visible   <= ~visible;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    bit_sel = 3'd7 - bit_addr_d;
    lit     = start_on_d & font_word[bit_sel] & visible;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      rgb     <= RGB_BLACK;
      text_px <= 1'b0;
    end else begin
      hsync   <= hsync_d;
      vsync   <= vsync_d;
      text_px <= lit & video_on_d;
      if (!video_on_d) begin
        rgb <= RGB_BLACK;
      end else if (lit) begin
        rgb <= TEXT_RGB;
      end else begin
        rgb <= bg_rgb_d;
      end
    end
  end

endmodule

// File: tb/tb_start_text_render.sv
// Directed bench for start_text_render with a pixel scoreboard.
// Expected {rgb,hsync,vsync,text_px} are queued at drive time and popped at the output.
module tb_start_text_render;

  localparam int BLINK = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_on, hsync_in, vsync_in, frame_tick, start_on, blink_en;
  logic [2:0]  bit_addr;
  logic [10:0] rom_addr;
  logic [11:0] bg_rgb;
  logic        hsync, vsync, text_px;
  logic [11:0] rgb;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  int          m_cnt;
  logic        m_vis;

  always #5 clk = ~clk;

  start_text_render #(.BLINK_FRAMES(BLINK), .TEXT_RGB(12'hFFF)) dut (
    .clk        (clk),
    .reset      (reset),
    .video_on   (video_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .frame_tick (frame_tick),
    .start_on   (start_on),
    .bit_addr   (bit_addr),
    .rom_addr   (rom_addr),
    .blink_en   (blink_en),
    .bg_rgb     (bg_rgb),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .text_px    (text_px)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Font words for the two addresses the bench uses, written out by hand.
  function automatic logic [7:0] ref_font(input logic [10:0] a);
    logic [7:0] w;
    w = 8'h00;
    if (a == 11'h535) w = 8'h83;
    else if (a == 11'h000) w = 8'h16;
    return w;
  endfunction

  task automatic step(input string tag, input logic vo, input logic hs, input logic vs,
                      input logic ft, input logic so, input logic [2:0] ba,
                      input logic [10:0] ra, input logic be, input logic [11:0] bg);
    logic [7:0]  fw;
    logic [2:0]  idx;
    logic        lit;
    logic [11:0] er;
    logic [15:0] e;
    @(negedge clk);
    video_on = vo; hsync_in = hs; vsync_in = vs; frame_tick = ft;
    start_on = so; bit_addr = ba; rom_addr = ra; blink_en = be; bg_rgb = bg;
    if (!be) begin
      m_cnt = 0; m_vis = 1'b1;
    end else if (ft) begin
      if (m_cnt == BLINK - 1) begin
        m_cnt = 0; m_vis = ~m_vis;
      end else begin
        m_cnt++;
      end
    end
    fw  = ref_font(ra);
    idx = 3'd7 - ba;
    lit = so & fw[idx] & m_vis;
    er  = !vo ? 12'h000 : (lit ? 12'hFFF : bg);
    exp_q.push_back({er, hs, vs, lit & vo});
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check(tag, {rgb, hsync, vsync, text_px}, e);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back({12'h000, 1'b1, 1'b1, 1'b0});
    m_cnt = 0;
    m_vis = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    video_on = 0; hsync_in = 1; vsync_in = 1; frame_tick = 0; start_on = 0;
    bit_addr = 0; rom_addr = 0; blink_en = 0; bg_rgb = 0;
    m_cnt = 0; m_vis = 1'b1;
    #12;
    check("reset_init", {rgb, hsync, vsync, text_px}, {12'h000, 1'b1, 1'b1, 1'b0});
    release_reset();

    // Glyph row 5 of char 0x53 across all eight columns.
    for (int b = 0; b < 8; b++)
      step("glyph", 1, 1, 1, 0, 1, 3'(b), 11'h535, 0, 12'h00F);
    for (int b = 0; b < 8; b++)
      step("glyph0", 1, 1, 1, 0, 1, 3'(b), 11'h000, 0, 12'h0A0);

    // Blanking on a lit bit; syncs keep moving.
    step("blank", 0, 0, 1, 0, 1, 3'd0, 11'h535, 0, 12'h00F);
    step("blank", 0, 1, 0, 0, 1, 3'd6, 11'h535, 0, 12'h00F);
    step("blank", 0, 0, 0, 0, 1, 3'd7, 11'h535, 0, 12'h00F);
    step("blank", 1, 1, 1, 0, 1, 3'd7, 11'h535, 0, 12'h00F);

    // Mid-stream async reset, with a frame_tick that must be ignored.
    step("pre_rst", 1, 0, 1, 0, 1, 3'd0, 11'h535, 1, 12'h00F);
    @(posedge clk);
    #2;
    reset = 1'b1;
    frame_tick = 1'b1;
    #1;
    check("reset_async", {rgb, hsync, vsync, text_px}, {12'h000, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    frame_tick = 1'b0;
    release_reset();
    step("post_rst0", 1, 0, 0, 0, 1, 3'd0, 11'h535, 0, 12'h123);
    step("post_rst1", 1, 1, 0, 0, 0, 3'd0, 11'h535, 0, 12'h456);
    step("post_rst2", 1, 1, 1, 0, 1, 3'd1, 11'h535, 0, 12'h789);

    // Blink: 30 ticks shown, 30 hidden, then shown again.
    for (int i = 1; i <= 2 * BLINK + 2; i++) begin
      step("blink_tick", 0, 1, 0, 1, 0, 3'd0, 11'h535, 1, 12'h0F0);
      step("blink_px", 1, 1, 1, 0, 1, 3'd0, 11'h535, 1, 12'h0F0);
    end

    // Disable on the 30th tick: no toggle, counter restarts.
    step("dis_clr", 1, 1, 1, 0, 1, 3'd0, 11'h535, 0, 12'h00F);
    for (int i = 1; i < BLINK; i++)
      step("dis_tick", 0, 1, 1, 1, 0, 3'd0, 11'h535, 1, 12'h00F);
    step("dis_30th", 0, 1, 1, 1, 0, 3'd0, 11'h535, 0, 12'h00F);
    step("dis_px", 1, 1, 1, 0, 1, 3'd0, 11'h535, 0, 12'h00F);
    for (int i = 1; i <= BLINK; i++) begin
      step("reen_tick", 0, 1, 1, 1, 0, 3'd0, 11'h535, 1, 12'h00F);
      step("reen_px", 1, 1, 1, 0, 1, 3'd0, 11'h535, 1, 12'h00F);
    end
    step("reen_off", 1, 1, 1, 0, 1, 3'd0, 11'h535, 0, 12'h00F);

    // Random syncs and pixels.
    for (int i = 0; i < 64; i++)
      step("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'($urandom),
           3'($urandom), ($urandom_range(0, 1) == 1) ? 11'h535 : 11'h000,
           1'b0, 12'($urandom));
    step("drain", 0, 1, 1, 0, 0, 3'd0, 11'h000, 0, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
